// File: rtl/axis_uart_arbiter.sv
// Round-robin AXI-Stream arbiter feeding a single UART TX stream.
// A grant lasts for one packet (until tlast) or MAX_BURST data beats,
// optionally preceded by a header beat identifying the granted source.
module axis_uart_arbiter #(
    parameter int          NUM_SRC     = 4,
    parameter int          MAX_BURST   = 0,
    parameter bit          HEADER_EN   = 1'b0,
    parameter logic [15:0] HEADER_BASE = 16'h00F0,
    localparam int         GW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NUM_SRC*16-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]      s_axis_tvalid,
    input  logic [NUM_SRC-1:0]      s_axis_tlast,
    output logic [NUM_SRC-1:0]      s_axis_tready,
    output logic [15:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [GW-1:0]           grant,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                     state;
    logic [GW-1:0]              last_grant;
    logic [15:0]                beat_cnt;
    logic [15:0]                hdr_data;

    logic [NUM_SRC-1:0][15:0]   src_data_arr;
    logic                       src_valid;
    logic                       src_last;
    logic                       beat_acc;
    logic [15:0]                cnt_nxt;
    logic                       burst_hit;
    logic                       req_any;
    logic [GW-1:0]              next_idx;
    logic [2*NUM_SRC-1:0]       req_rot;
    logic [GW+1:0]              idx_sum;

    assign src_data_arr = s_axis_tdata;

    // Round-robin pick: rotate requests so last_grant+1 lands at bit 0,
    // then take the lowest set bit and map it back to a source index.
    always_comb begin
        req_rot  = {s_axis_tvalid, s_axis_tvalid} >> ({1'b0, last_grant} + 1'b1);
        req_any  = |s_axis_tvalid;
        idx_sum  = '0;
        next_idx = last_grant;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                idx_sum = (GW+2)'(last_grant) + (GW+2)'(j + 1);
                if (idx_sum >= (GW+2)'(NUM_SRC))
                    idx_sum = idx_sum - (GW+2)'(NUM_SRC);
                next_idx = idx_sum[GW-1:0];
            end
        end
    end

    // Granted-source view and beat accounting; the counter saturates so an
    // unlimited grant can never alias onto a burst limit.
    always_comb begin
        src_valid = s_axis_tvalid[grant];
        src_last  = s_axis_tlast[grant];
        beat_acc  = (state == DATA) && src_valid && m_axis_tready;
        cnt_nxt   = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
        burst_hit = (MAX_BURST != 0) && (cnt_nxt == 16'(MAX_BURST));
    end

    // Output mux: header beat from a register, data passed straight through.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        case (state)
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_data;
            end
            DATA: begin
                m_axis_tvalid        = src_valid;
                m_axis_tdata         = src_data_arr[grant];
                s_axis_tready[grant] = m_axis_tready;
            end
            default: ;
        endcase
    end

    // Arbitration FSM with registered grant/busy/header state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_SRC - 1);
            grant      <= GW'(NUM_SRC - 1);
            beat_cnt   <= '0;
            busy       <= 1'b0;
            hdr_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant    <= next_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        hdr_data <= HEADER_BASE + 16'(next_idx);
                        state    <= HEADER_EN ? HEADER : DATA;
                    end
                end
                HEADER: begin
                    if (m_axis_tready)
                        state <= DATA;
                end
                DATA: begin
                    if (beat_acc) begin
                        beat_cnt <= cnt_nxt;
                        if (src_last || burst_hit) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            last_grant <= grant;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_arbiter.sv
// Scoreboard bench for axis_uart_arbiter: sources play out queued packets,
// a packet-level round-robin model predicts the output beat sequence and a
// monitor checks every accepted output beat against it.
module tb_axis_uart_arbiter;

    localparam int          N  = 4;
    localparam int          MB = 2;
    localparam logic [15:0] HB = 16'h00F0;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [N*16-1:0]   s_tdata;
    logic [N-1:0]      s_tvalid, s_tlast, s_tready;
    logic [15:0]       m_tdata;
    logic              m_tvalid, m_tready;
    logic [1:0]        grant;
    logic              busy;

    always #5 aclk = ~aclk;

    axis_uart_arbiter #(
        .NUM_SRC(N), .MAX_BURST(MB), .HEADER_EN(1'b1), .HEADER_BASE(HB)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .grant(grant), .busy(busy)
    );

    typedef struct {
        logic [15:0] data;
        int          src;
        bit          hdr;
        bit          eop;
    } exp_t;

    exp_t        expq[$];
    logic [16:0] srcq[N][$];   // {tlast, tdata} still to be sent
    logic [16:0] mq[N][$];     // model's copy of the same packets
    int          tests = 0, fails = 0, popped = 0;
    int          rdy_mode = 0;
    bit          gap_en = 1'b0;
    int          mdl_last = N - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic load_pkt(input int s, input int len);
        logic [31:0] d;
        logic [16:0] w;
        for (int b = 0; b < len; b++) begin
            d = $urandom;
            w = {(b == len - 1), d[15:0]};
            srcq[s].push_back(w);
            mq[s].push_back(w);
        end
    endtask

    // Packet-level round robin: each grant is a header plus beats up to tlast
    // or MB beats, next grant searched upward from the previous one.
    task automatic model_round();
        int          s, n;
        bit          any, e;
        logic [16:0] b;
        any = 1'b1;
        while (any) begin
            s = -1;
            for (int k = 1; k <= N; k++)
                if (s < 0 && mq[(mdl_last + k) % N].size() > 0) s = (mdl_last + k) % N;
            if (s < 0) begin
                any = 1'b0;
            end else begin
                expq.push_back('{data: HB + 16'(s), src: s, hdr: 1'b1, eop: 1'b0});
                n = 0;
                e = 1'b0;
                while (!e) begin
                    b = mq[s].pop_front();
                    n++;
                    e = b[16] || (MB != 0 && n == MB);
                    expq.push_back('{data: b[15:0], src: s, hdr: 1'b0, eop: e});
                end
                mdl_last = s;
            end
        end
    endtask

    function automatic bit srcs_empty();
        bit r = 1'b1;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic run_round(input int maxcyc);
        int c = 0;
        model_round();
        while ((expq.size() != 0 || !srcs_empty()) && c < maxcyc) begin
            @(negedge aclk);
            c++;
        end
        if (c >= maxcyc) begin
            tests++;
            fails++;
            $display("FAIL round_timeout: %0d beats still expected after %0d cycles", expq.size(), maxcyc);
            expq.delete();
            for (int i = 0; i < N; i++) begin srcq[i].delete(); mq[i].delete(); end
        end
        repeat (3) @(negedge aclk);
        chk("end_idle_busy", busy, 0);
    endtask

    // Source and sink driver: handshakes sampled mid-cycle, new values applied
    // just after each rising edge.
    initial begin
        logic [N-1:0] hs, stall;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        forever begin
            @(negedge aclk);
            hs    = s_tvalid & s_tready;
            stall = s_tvalid & ~s_tready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    s_tvalid[i] = !(gap_en && !stall[i] && $urandom_range(3) == 0);
                    s_tdata[i*16 +: 16] = srcq[i][0][15:0];
                    s_tlast[i] = srcq[i][0][16];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tdata[i*16 +: 16] = '0;
                    s_tlast[i] = 1'b0;
                end
            end
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = 1'($urandom_range(1));
                2: m_tready = 1'b0;
                default: m_tready = ~m_tready;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted output beat.
    initial begin
        exp_t        e;
        bit          pv = 1'b0, idle_chk = 1'b0;
        logic [15:0] pd = '0;
        logic [N-1:0] allow;
        forever begin
            @(negedge aclk);
            if (areset) begin
                pv = 1'b0;
                idle_chk = 1'b0;
                continue;
            end
            if (pv) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", m_tdata, pd);
            end
            pv = m_tvalid && !m_tready;
            pd = m_tdata;
            allow = m_tready ? (N'(1) << grant) : '0;
            chk("ready_leak", s_tready & ~allow, 0);
            if (idle_chk) begin
                chk("dead_cycle_valid", m_tvalid, 0);
                chk("dead_cycle_busy", busy, 0);
                idle_chk = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got %0h expected no beat", m_tdata);
                end else begin
                    e = expq.pop_front();
                    chk(e.hdr ? "hdr_data" : "beat_data", m_tdata, e.data);
                    chk("beat_grant", grant, e.src);
                    chk("beat_busy", busy, 1);
                    chk(e.hdr ? "hdr_src_ready" : "beat_src_ready", s_tready,
                        e.hdr ? 0 : (32'd1 << e.src));
                    idle_chk = e.eop;
                    popped++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, mask, base;
        // Reset state.
        @(negedge aclk);
        chk("rst_valid", m_tvalid, 0);
        chk("rst_data", m_tdata, 0);
        chk("rst_ready", s_tready, 0);
        chk("rst_grant", grant, N - 1);
        chk("rst_busy", busy, 0);
        #2 areset = 1'b0;
        repeat (2) @(negedge aclk);

        // Single source, three beats.
        srcq[1].push_back(17'h00041); mq[1].push_back(17'h00041);
        srcq[1].push_back(17'h00042); mq[1].push_back(17'h00042);
        srcq[1].push_back(17'h10043); mq[1].push_back(17'h10043);
        run_round(200);

        // Fairness: every source queues several one-beat packets.
        for (int s = 0; s < N; s++) for (int p = 0; p < 3; p++) load_pkt(s, 1);
        run_round(400);

        // Header insertion for src2.
        srcq[2].push_back(17'h10055); mq[2].push_back(17'h10055);
        run_round(100);

        // Burst limit splits a long packet while another source waits.
        load_pkt(0, 5);
        load_pkt(1, 2);
        run_round(400);

        // Backpressure on the header, then toggling ready.
        rdy_mode = 2;
        load_pkt(1, 3);
        load_pkt(3, 2);
        model_round();
        repeat (11) @(negedge aclk);
        chk("bp_hdr_valid", m_tvalid, 1);
        chk("bp_hdr_data", m_tdata, expq[0].data);
        chk("bp_hdr_ready", s_tready, 0);
        rdy_mode = 3;
        run_round(400);

        // Reset in the middle of a data grant.
        rdy_mode = 0;
        load_pkt(2, 2);
        model_round();
        base = popped;
        for (int c = 0; c < 200 && popped < base + 2; c++) @(negedge aclk);
        chk("rst_mid_reached", popped, base + 2);
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        chk("rst_mid_valid", m_tvalid, 0);
        chk("rst_mid_data", m_tdata, 0);
        chk("rst_mid_ready", s_tready, 0);
        chk("rst_mid_grant", grant, N - 1);
        chk("rst_mid_busy", busy, 0);
        expq.delete();
        for (int i = 0; i < N; i++) begin srcq[i].delete(); mq[i].delete(); end
        mdl_last = N - 1;
        repeat (2) @(posedge aclk);
        #3 areset = 1'b0;
        load_pkt(3, 2);
        load_pkt(0, 1);
        run_round(200);

        // Randomized rounds.
        for (int r = 0; r < 25; r++) begin
            mask = $urandom_range(1, (1 << N) - 1);
            nb = $countones(mask[N-1:0]);
            gap_en = (nb == 1);
            rdy_mode = $urandom_range(1);
            for (int s = 0; s < N; s++)
                if (mask[s]) for (int p = 0; p < $urandom_range(1, 3); p++)
                    load_pkt(s, $urandom_range(1, 5));
            run_round(3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
